// File: rtl/cla_sub_nibble_serial_if.sv
// ---------------------------------------------------------------------------
// cla_sub_nibble_serial_if
//
// Purpose: bundles the operand (request) and result (response) valid/ready
// channels of the nibble-serial CLA subtractor.
//
// Signals:
//   in_valid / in_ready      : operand handshake (producer -> subtractor)
//   a, b [WIDTH]             : minuend, subtrahend
//   borrow_in                : borrow into bit 0
//   sub                      : 1 = subtract, 0 = add (only with CLA_SUB_ADD_MODE_EN)
//   out_valid / out_ready    : result handshake (subtractor -> consumer)
//   diff [WIDTH]             : registered result
//   borrow_out, overflow     : unsigned borrow (or carry in add mode), signed overflow
//
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the subtractor itself
//
// Optional feature macro: CLA_SUB_ADD_MODE_EN (adds the 'sub' signal).
// ---------------------------------------------------------------------------
interface cla_sub_nibble_serial_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
`ifdef CLA_SUB_ADD_MODE_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             overflow;

    modport master (
`ifdef CLA_SUB_ADD_MODE_EN
        output sub,
`endif
        output in_valid, a, b, borrow_in, out_ready,
        input  in_ready, out_valid, diff, borrow_out, overflow
    );

    modport slave (
`ifdef CLA_SUB_ADD_MODE_EN
        input  sub,
`endif
        input  in_valid, a, b, borrow_in, out_ready,
        output in_ready, out_valid, diff, borrow_out, overflow
    );
endinterface

// File: rtl/cla_sub_nibble_serial.sv
// ---------------------------------------------------------------------------
// cla_sub_nibble_serial
//
// Purpose: WIDTH-bit subtractor (diff = a - b - borrow_in) built around a
// single 4-bit carry-lookahead slice. One nibble is processed per clock,
// least significant first; the carry (= NOT borrow) is registered between
// nibbles. Result latency is WIDTH/4 cycles after the accept edge.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : cla_sub_nibble_serial_if.slave
//            in_valid/in_ready/a/b/borrow_in  -- operand channel
//            out_valid/out_ready/diff/borrow_out/overflow -- result channel
//
// Optional feature macro: CLA_SUB_ADD_MODE_EN
//   When defined, bus.sub is sampled at accept: sub=0 computes
//   a + b + borrow_in and borrow_out then reports the plain carry out.
// ---------------------------------------------------------------------------
module cla_sub_nibble_serial #(
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    cla_sub_nibble_serial_if.slave   bus
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [CW-1:0] LAST_NIB = CW'(NIB - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] b_q,         b_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             c_q,         c_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             borrow_q,    borrow_d;
    logic             ovf_q,       ovf_d;
    logic             out_valid_q, out_valid_d;

    // sub_mode: operation of the transaction in flight; sub_in: operation
    // requested on the accepting edge.
    logic             sub_mode;
    logic             sub_in;

`ifdef CLA_SUB_ADD_MODE_EN
    logic             sub_q, sub_d;
    assign sub_mode = sub_q;
    assign sub_in   = bus.sub;
`else
    assign sub_mode = 1'b1;
    assign sub_in   = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Nibble selection
    // ------------------------------------------------------------------
    logic [3:0] a_nibs [NIB];
    logic [3:0] b_nibs [NIB];

    for (genvar gi = 0; gi < NIB; gi++) begin : g_split
        assign a_nibs[gi] = a_q[4*gi +: 4];
        assign b_nibs[gi] = b_q[4*gi +: 4];
    end

    logic [3:0] a_nib;
    logic [3:0] b_eff;   // ~b for subtract, b for add
    assign a_nib = a_nibs[cnt_q];
    assign b_eff = sub_mode ? ~b_nibs[cnt_q] : b_nibs[cnt_q];

    // ------------------------------------------------------------------
    // 4-bit carry-lookahead slice, flat two-level sum of products
    // ------------------------------------------------------------------
    logic [3:0] p;
    logic [3:0] g;
    logic       c1, c2, c3, c4;
    logic [3:0] sum_nib;

    assign p = a_nib ^ b_eff;
    assign g = a_nib & b_eff;

    assign c1 = g[0]
              | (p[0] & c_q);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & c_q);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c_q);
    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c_q);

    assign sum_nib = p ^ {c3, c2, c1, c_q};

    // ------------------------------------------------------------------
    // Result accumulator: only the nibble at the current index updates
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NIB; gi++) begin : g_diff
        assign diff_d[4*gi +: 4] = (state_q == S_BUSY && cnt_q == CW'(gi))
                                 ? sum_nib
                                 : diff_q[4*gi +: 4];
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        borrow_d    = borrow_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
`ifdef CLA_SUB_ADD_MODE_EN
        sub_d       = sub_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    cnt_d   = '0;
                    // subtract runs as a + ~b + carry, carry = NOT borrow
                    c_d     = sub_in ? ~bus.borrow_in : bus.borrow_in;
`ifdef CLA_SUB_ADD_MODE_EN
                    sub_d   = bus.sub;
`endif
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                c_d   = c4;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_NIB) begin
                    cnt_d       = '0;
                    borrow_d    = sub_mode ? ~c4 : c4;
                    // c3 is the carry into the MSB of the whole word
                    ovf_d       = c3 ^ c4;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            cnt_q       <= '0;
            c_q         <= 1'b0;
            diff_q      <= '0;
            borrow_q    <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CLA_SUB_ADD_MODE_EN
            sub_q       <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            diff_q      <= diff_d;
            borrow_q    <= borrow_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
`ifdef CLA_SUB_ADD_MODE_EN
            sub_q       <= sub_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = out_valid_q;
    assign bus.diff       = diff_q;
    assign bus.borrow_out = borrow_q;
    assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_cla_sub_nibble_serial.sv
// ---------------------------------------------------------------------------
// tb_cla_sub_nibble_serial
//
// Purpose: self-checking bench for cla_sub_nibble_serial (WIDTH = 16).
// A transaction-level reference (plain integer arithmetic plus a latency
// countdown) predicts in_ready/out_valid/diff/borrow_out/overflow and is
// compared against the DUT every falling edge. Directed operations pin the
// reference with hand-computed literals; a randomized phase follows.
// Optional feature macro: CLA_SUB_ADD_MODE_EN (adds add-mode cases).
// ---------------------------------------------------------------------------
module tb_cla_sub_nibble_serial;
    localparam int W   = 16;
    localparam int LAT = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cla_sub_nibble_serial_if #(.WIDTH(W)) bus();

    cla_sub_nibble_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: returns {borrow_or_carry, overflow, result}
    function automatic logic [17:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic bin, input logic sub);
        int          sa, sb, r;
        logic [16:0] u;
        sa = $signed(a);
        sb = $signed(b);
        if (sub) begin
            u = {1'b0, a} - {1'b0, b} - 17'(bin);
            r = sa - sb - int'(bin);
        end else begin
            u = {1'b0, a} + {1'b0, b} + 17'(bin);
            r = sa + sb + int'(bin);
        end
        return {u[16], (r > 32767 || r < -32768), u[15:0]};
    endfunction

    logic cur_sub;
`ifdef CLA_SUB_ADD_MODE_EN
    assign cur_sub = bus.sub;
`else
    assign cur_sub = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Transaction-level reference: idle -> countdown of LAT edges -> hold
    // ------------------------------------------------------------------
    logic        m_idle = 1'b1;
    logic        m_ov   = 1'b0;
    int          m_left = 0;
    logic [17:0] m_pend = '0;
    logic [17:0] m_res  = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_ov   <= 1'b0;
            m_left <= 0;
            m_res  <= '0;
        end else if (m_idle) begin
            if (bus.in_valid) begin
                m_pend <= ref_op(bus.a, bus.b, bus.borrow_in, cur_sub);
                m_left <= LAT;
                m_idle <= 1'b0;
            end
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
            end
        end else if (bus.out_ready) begin
            m_ov   <= 1'b0;
            m_idle <= 1'b1;
            n_txn  <= n_txn + 1;
            $display("txn %0d: diff=%04h borrow_out=%0b overflow=%0b",
                     n_txn, bus.diff, bus.borrow_out, bus.overflow);
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        check("cyc_in_ready",  {31'd0, bus.in_ready},  {31'd0, m_idle});
        check("cyc_out_valid", {31'd0, bus.out_valid}, {31'd0, m_ov});
        if (m_ov || !rst_n) begin
            check("cyc_diff",       {16'd0, bus.diff},       {16'd0, m_res[15:0]});
            check("cyc_borrow_out", {31'd0, bus.borrow_out}, {31'd0, m_res[17]});
            check("cyc_overflow",   {31'd0, bus.overflow},   {31'd0, m_res[16]});
        end
    end

    // ------------------------------------------------------------------
    // Directed operation with literal expectations.
    // hold: cycles out_ready stays low after out_valid; a stray in_valid
    // with fresh operands is pulsed during the hold when hold > 1.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                          input logic sub, input logic [15:0] e_diff, input logic e_bo,
                          input logic e_of, input int hold, input string tag);
        int waitc;
        int lat;
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        check({tag, "_ready_timeout"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid  = 1'b1;
        bus.a         = a;
        bus.b         = b;
        bus.borrow_in = bin;
`ifdef CLA_SUB_ADD_MODE_EN
        bus.sub       = sub;
`else
        if (!sub) $display("note: add-mode op requested without add mode, ran as subtract");
`endif
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.a         = 16'($urandom);
        bus.b         = 16'($urandom);
        bus.borrow_in = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"},    lat, LAT);
        check({tag, "_diff"},       {16'd0, bus.diff},       {16'd0, e_diff});
        check({tag, "_borrow_out"}, {31'd0, bus.borrow_out}, {31'd0, e_bo});
        check({tag, "_overflow"},   {31'd0, bus.overflow},   {31'd0, e_of});
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                bus.in_valid = 1'b1;
                bus.a        = 16'h0F0F;
                bus.b        = 16'h1111;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, {31'd0, bus.out_valid}, 32'd1);
            check({tag, "_hold_ready"}, {31'd0, bus.in_ready},  32'd0);
            check({tag, "_hold_diff"},  {16'd0, bus.diff},      {16'd0, e_diff});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check({tag, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, "_post_ready"}, {31'd0, bus.in_ready},  32'd1);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(7))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h8000;
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.borrow_in = 1'b0;
        bus.out_ready = 1'b0;
`ifdef CLA_SUB_ADD_MODE_EN
        bus.sub       = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_diff",      {16'd0, bus.diff},      32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(16'h1234, 16'h0034, 1'b0, 1'b1, 16'h1200, 1'b0, 1'b0, 0, "basic");
        run_op(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, "wrap");
        run_op(16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 0, "bin");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0, "sovf");
        run_op(16'h1234, 16'h0034, 1'b0, 1'b1, 16'h1200, 1'b0, 1'b0, 5, "backpressure");

        // Reset in the middle of an operation
        bus.in_valid = 1'b1;
        bus.a        = 16'hAAAA;
        bus.b        = 16'h5555;
        bus.borrow_in = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready",   {31'd0, bus.in_ready},   32'd1);
        check("midrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        check("midrst_diff",       {16'd0, bus.diff},       32'd0);
        check("midrst_borrow_out", {31'd0, bus.borrow_out}, 32'd0);
        check("midrst_overflow",   {31'd0, bus.overflow},   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'd0, bus.out_valid}, 32'd0);
        end
        run_op(16'h00FF, 16'h000F, 1'b0, 1'b1, 16'h00F0, 1'b0, 1'b0, 0, "after_rst");

`ifdef CLA_SUB_ADD_MODE_EN
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, "add_ovf");
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, "add_wrap");
`endif

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk); #1;
            bus.in_valid  = 1'($urandom_range(1));
            bus.a         = pick_operand();
            bus.b         = pick_operand();
            bus.borrow_in = 1'($urandom_range(1));
            bus.out_ready = ($urandom_range(3) != 0);
`ifdef CLA_SUB_ADD_MODE_EN
            bus.sub       = 1'($urandom_range(1));
`endif
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("drain_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("drain_out_valid", {31'd0, bus.out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
